// File: rtl/tournament_predictor_pkg.sv
// Shared definitions for the tournament branch predictor: FSM states, counter init values,
// table-sizing helper and the saturating counter step.
package tournament_predictor_pkg;

  localparam int unsigned CNT_W_DFLT = 2;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

  function automatic int unsigned max_idx(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Weakly not-taken
  function automatic int unsigned wnt_val(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

  // Weakly prefer gshare
  function automatic int unsigned wgsh_val(input int unsigned cnt_w);
    return 32'd1 << (cnt_w - 1);
  endfunction

  function automatic logic [31:0] sat_step(input logic [31:0] cnt, input logic up,
                                           input int unsigned cnt_w);
    logic [31:0] cnt_max;
    cnt_max = (32'd1 << cnt_w) - 32'd1;
    if (up) begin
      return (cnt == cnt_max) ? cnt : cnt + 32'd1;
    end
    return (cnt == 32'd0) ? cnt : cnt - 32'd1;
  endfunction

endpackage

// File: rtl/tournament_predictor_sat_cnt_table.sv
// Array of saturating counters: combinational read, read-modify-write update port and an
// init-write port that takes priority over updates.
module tournament_predictor_sat_cnt_table
  import tournament_predictor_pkg::*;
#(
  parameter int unsigned IDX_W = 10,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_up,
  output logic [CNT_W-1:0] upd_cnt,
  input  logic             init_en,
  input  logic [IDX_W-1:0] init_idx,
  input  logic [CNT_W-1:0] init_val
);

  localparam int unsigned Depth = 1 << IDX_W;

  logic [CNT_W-1:0] mem [Depth];
  logic [CNT_W-1:0] upd_nxt;

  assign rd_cnt  = mem[rd_idx];
  assign upd_cnt = mem[upd_idx];
  assign upd_nxt = CNT_W'(sat_step(32'(upd_cnt), upd_up, CNT_W));

  // Contents are not reset; the owner sweeps init_idx over the table after reset.
  always_ff @(posedge clk) begin
    if (init_en) begin
      mem[init_idx] <= init_val;
    end else if (upd_en) begin
      mem[upd_idx] <= upd_nxt;
    end
  end

endmodule

// File: rtl/tournament_predictor.sv
// Tournament predictor: gshare + per-address two-level local, chosen per PC, with
// speculative GHR, mispredict repair, post-reset table sweep and registered prediction.
module tournament_predictor
  import tournament_predictor_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned GHR_W     = 10,
  parameter int unsigned BHT_IDX_W = 8,
  parameter int unsigned LHIST_W   = 10,
  parameter int unsigned CHO_IDX_W = 10,
  parameter int unsigned CNT_W     = CNT_W_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pred_req,
  input  logic [ADDR_W-1:0] pred_pc,
  output logic              pred_rdy,
  output logic              pred_vld,
  output logic              pred_taken,
  output logic              pred_gsh,
  output logic              pred_loc,
  output logic              pred_sel,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              upd_vld,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [GHR_W-1:0]  upd_ghr,
  input  logic              upd_mispred
);

  localparam int unsigned MaxIdx = max_idx(GHR_W, BHT_IDX_W, LHIST_W, CHO_IDX_W);
  localparam logic [CNT_W-1:0] Wnt  = CNT_W'(wnt_val(CNT_W));
  localparam logic [CNT_W-1:0] Wgsh = CNT_W'(wgsh_val(CNT_W));

  state_e              state_q;
  logic [MaxIdx-1:0]   init_cnt_q;
  logic [GHR_W-1:0]    ghr_q;
  logic [LHIST_W-1:0]  bht [1 << BHT_IDX_W];

  logic                init_active, req_acc, upd_acc;
  logic                gsh_init_en, bht_init_en, loc_init_en, cho_init_en;

  logic [GHR_W-1:0]     gsh_rd_idx, gsh_upd_idx;
  logic [BHT_IDX_W-1:0] bht_rd_idx, bht_upd_idx;
  logic [LHIST_W-1:0]   loc_rd_idx, loc_upd_idx;
  logic [CHO_IDX_W-1:0] cho_rd_idx, cho_upd_idx;

  logic [CNT_W-1:0]     gsh_rd_cnt, loc_rd_cnt, cho_rd_cnt;
  logic [CNT_W-1:0]     gsh_upd_cnt, loc_upd_cnt, unused_cho_cnt;

  logic                 gsh_dir, loc_dir, cho_dir, taken_c;
  logic                 gsh_upd_dir, loc_upd_dir, cho_upd_en, cho_upd_up;
  logic                 unused_pc;

  assign unused_pc   = ^{pred_pc, upd_pc};

  assign init_active = (state_q == StInit);
  assign pred_rdy    = (state_q == StRun);
  assign req_acc     = pred_req && pred_rdy;
  assign upd_acc     = upd_vld && pred_rdy;

  // Sweep indices past a table's depth are dropped
  assign gsh_init_en = init_active && ((32'(init_cnt_q) >> GHR_W) == 32'd0);
  assign bht_init_en = init_active && ((32'(init_cnt_q) >> BHT_IDX_W) == 32'd0);
  assign loc_init_en = init_active && ((32'(init_cnt_q) >> LHIST_W) == 32'd0);
  assign cho_init_en = init_active && ((32'(init_cnt_q) >> CHO_IDX_W) == 32'd0);

  assign gsh_rd_idx  = ghr_q ^ pred_pc[GHR_W+1:2];
  assign bht_rd_idx  = pred_pc[BHT_IDX_W+1:2];
  assign loc_rd_idx  = bht[bht_rd_idx];
  assign cho_rd_idx  = pred_pc[CHO_IDX_W+1:2];

  assign gsh_upd_idx = upd_ghr ^ upd_pc[GHR_W+1:2];
  assign bht_upd_idx = upd_pc[BHT_IDX_W+1:2];
  assign loc_upd_idx = bht[bht_upd_idx];
  assign cho_upd_idx = upd_pc[CHO_IDX_W+1:2];

  assign gsh_dir     = gsh_rd_cnt[CNT_W-1];
  assign loc_dir     = loc_rd_cnt[CNT_W-1];
  assign cho_dir     = cho_rd_cnt[CNT_W-1];
  assign taken_c     = cho_dir ? gsh_dir : loc_dir;

  // Chooser trains only when the components disagree, toward whichever was right
  assign gsh_upd_dir = gsh_upd_cnt[CNT_W-1];
  assign loc_upd_dir = loc_upd_cnt[CNT_W-1];
  assign cho_upd_en  = upd_acc && (gsh_upd_dir != loc_upd_dir);
  assign cho_upd_up  = (gsh_upd_dir == upd_taken);

  tournament_predictor_sat_cnt_table #(
    .IDX_W (GHR_W),
    .CNT_W (CNT_W)
  ) u_gsh_pht (
    .clk      (clk),
    .rd_idx   (gsh_rd_idx),
    .rd_cnt   (gsh_rd_cnt),
    .upd_en   (upd_acc),
    .upd_idx  (gsh_upd_idx),
    .upd_up   (upd_taken),
    .upd_cnt  (gsh_upd_cnt),
    .init_en  (gsh_init_en),
    .init_idx (GHR_W'(init_cnt_q)),
    .init_val (Wnt)
  );

  tournament_predictor_sat_cnt_table #(
    .IDX_W (LHIST_W),
    .CNT_W (CNT_W)
  ) u_loc_pht (
    .clk      (clk),
    .rd_idx   (loc_rd_idx),
    .rd_cnt   (loc_rd_cnt),
    .upd_en   (upd_acc),
    .upd_idx  (loc_upd_idx),
    .upd_up   (upd_taken),
    .upd_cnt  (loc_upd_cnt),
    .init_en  (loc_init_en),
    .init_idx (LHIST_W'(init_cnt_q)),
    .init_val (Wnt)
  );

  tournament_predictor_sat_cnt_table #(
    .IDX_W (CHO_IDX_W),
    .CNT_W (CNT_W)
  ) u_chooser (
    .clk      (clk),
    .rd_idx   (cho_rd_idx),
    .rd_cnt   (cho_rd_cnt),
    .upd_en   (cho_upd_en),
    .upd_idx  (cho_upd_idx),
    .upd_up   (cho_upd_up),
    .upd_cnt  (unused_cho_cnt),
    .init_en  (cho_init_en),
    .init_idx (CHO_IDX_W'(init_cnt_q)),
    .init_val (Wgsh)
  );

  always_ff @(posedge clk) begin
    if (bht_init_en) begin
      bht[BHT_IDX_W'(init_cnt_q)] <= '0;
    end else if (upd_acc) begin
      bht[bht_upd_idx] <= {loc_upd_idx[LHIST_W-2:0], upd_taken};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      ghr_q      <= '0;
      pred_vld   <= 1'b0;
      pred_taken <= 1'b0;
      pred_gsh   <= 1'b0;
      pred_loc   <= 1'b0;
      pred_sel   <= 1'b0;
      pred_ghr   <= '0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (init_cnt_q == '1) begin
            state_q <= StRun;
          end else begin
            init_cnt_q <= init_cnt_q + MaxIdx'(1);
          end
        end
        StRun: state_q <= StRun;
      endcase

      pred_vld <= req_acc;
      if (req_acc) begin
        pred_taken <= taken_c;
        pred_gsh   <= gsh_dir;
        pred_loc   <= loc_dir;
        pred_sel   <= cho_dir;
        pred_ghr   <= ghr_q;
      end

      // Repair overrides the same cycle's speculative shift
      if (upd_acc && upd_mispred) begin
        ghr_q <= {upd_ghr[GHR_W-2:0], upd_taken};
      end else if (req_acc) begin
        ghr_q <= {ghr_q[GHR_W-2:0], taken_c};
      end
    end
  end

endmodule
